// File: rtl/instr_data_mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Arbiter FSM encoding and the captured memory request layout.
package instr_data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DATA = 2'd1,
    ARB_INST = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_type;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_type;

  localparam int RUN_CNT_W = 4;

endpackage

// File: rtl/instr_data_mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around the arbiter.
// slave = arbiter view, master = pipeline plus memory view.
interface instr_data_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;

  logic              dm_read;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instr_data_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data wins arbitration; a saturating run counter forces fetch after MAX_DM_RUN data grants.
//
// state    | meaning
// ARB_IDLE | arbitrate between pending fetch and data requests
// ARB_DATA | load/store in flight, waiting for mem_ack
// ARB_INST | fetch in flight, waiting for mem_ack
// ARB_DONE | owner's ready pulse is high; forces one idle cycle
module instr_data_mem_arbiter
  import instr_data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MAX_DM_RUN = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  instr_data_mem_arbiter_if.slave  bus
);

  localparam logic [RUN_CNT_W-1:0] RUN_MAX = RUN_CNT_W'(MAX_DM_RUN);

  arb_state_type         r_state;
  logic [RUN_CNT_W-1:0]  r_run_cnt;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_is_load;
  logic [31:0]           r_if_rdata;
  logic [31:0]           r_dm_rdata;
  logic                  r_if_ready;
  logic                  r_dm_ready;

  logic                  w_dm_pend;
  logic                  w_force_if;

  assign w_dm_pend  = bus.dm_read | bus.dm_write;
  assign w_force_if = bus.if_req && (r_run_cnt == RUN_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ARB_IDLE;
      r_run_cnt   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_is_load   <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ready  <= 1'b0;
      r_dm_ready  <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_dm_pend && !w_force_if) begin
            r_state     <= ARB_DATA;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.dm_write;
            r_mem_addr  <= bus.dm_addr;
            r_mem_wdata <= bus.dm_wdata;
            r_is_load   <= !bus.dm_write;
            // only contended data grants count toward starving fetch
            if (bus.if_req) r_run_cnt <= r_run_cnt + 1'b1;
          end else if (bus.if_req) begin
            r_state     <= ARB_INST;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= '0;
            r_is_load   <= 1'b0;
            r_run_cnt   <= '0;
          end
        end
        ARB_DATA: begin
          if (bus.mem_ack) begin
            r_state    <= ARB_DONE;
            r_mem_req  <= 1'b0;
            r_dm_ready <= 1'b1;
            if (r_is_load) r_dm_rdata <= bus.mem_rdata;
          end
        end
        ARB_INST: begin
          if (bus.mem_ack) begin
            r_state    <= ARB_DONE;
            r_mem_req  <= 1'b0;
            r_if_ready <= 1'b1;
            r_if_rdata <= bus.mem_rdata;
          end
        end
        ARB_DONE: r_state <= ARB_IDLE;
        default:  r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_ready  = r_if_ready;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.dm_ready  = r_dm_ready;

endmodule
